seven_segment_reader: RTL and testbench
=======================================

Name: seven_segment_reader

Overview:
- Receive-side counterpart of the seven-segment seconds display.
- Samples a 7-bit segment bus from user IO pads, filters glitches and recovers the displayed digit 0-9.
- Checks that each new digit is the previous digit +1 mod 10, and measures the clk-cycle period between digit changes.
- Used for on-chip loopback self-test of the display driver and for reading external seven-segment sources.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles a pattern must hold before acceptance; legal range 2..255.
- PERIOD_W, 24: width of the period counter and the period output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- seg_in  in  7  raw segment levels, asynchronous to clk; bit i = segment i+1 (bit0 top, bit6 middle)
- clear_flags  in  1  one-cycle pulse; clears the sticky flags
- io_oeb  out  7  constant 7'h7F (pads configured as inputs)
- digit  out  4  last accepted valid digit
- digit_strobe  out  1  one-cycle pulse when digit is updated
- digit_locked  out  1  high while the last accepted pattern was a valid digit
- period  out  PERIOD_W  clk cycles between the last two strobes
- period_valid  out  1  one-cycle pulse, coincident with digit_strobe, when period is updated
- bad_pattern  out  1  sticky: a non-digit pattern was accepted
- seq_error  out  1  sticky: an accepted digit broke the +1 mod 10 sequence

Behaviour:
- Reset values:
  - digit=0, digit_strobe=0, digit_locked=0, period=0, period_valid=0, bad_pattern=0, seq_error=0.
  - Internal state: synchronizer=0, candidate=0, accepted pattern=0, stability count=0, period counter=0.
- Synchronizer: two flops on seg_in, giving seg_s. No logic on seg_in before the first flop.
- Stability filter:
  - If seg_s != candidate: candidate<=seg_s and count<=0.
  - Otherwise count increments, saturating at STABLE_CYCLES-1.
  - Accept event: count==STABLE_CYCLES-1 AND (candidate != accepted pattern OR digit_locked==0 after reset/bad). The accepted pattern is then updated.
  - Exactly one accept per stable change.
  - A pulse shorter than STABLE_CYCLES cycles is ignored.
  - Returning to the accepted pattern after a glitch produces no accept.
- Latency: seg_in changes and is held; the first clk edge sampling the new value is edge 0. Outputs update at edge STABLE_CYCLES+2 (edge 6 at default).
- Decode table, 7'h values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7C, 7=07, 8=7F, 9=67. Any other value, including 00, is invalid.
- State machine, two states:
  - UNLOCKED (reset):
    - Accepted valid pattern -> digit<=decoded, digit_strobe=1, no sequence check, no period_valid, period counter<=1, go to LOCKED.
    - Accepted invalid pattern -> bad_pattern<=1, stay UNLOCKED.
  - LOCKED:
    - Accepted valid pattern d:
      - digit<=d, digit_strobe=1, period<=period counter, period_valid=1, period counter<=1.
      - If d != (digit+1) mod 10 (9 wraps to 0), seq_error<=1.
    - Accepted invalid pattern -> bad_pattern<=1, digit holds, no strobe, go to UNLOCKED.
- Period counter:
  - Increments every cycle, saturating at 2^PERIOD_W-1; no wrap.
  - period equals the edge distance between consecutive strobes in LOCKED.
- Sticky flags: clear_flags clears bad_pattern and seq_error. If a set event occurs in the same cycle as clear_flags, set wins.
- Reset mid-operation: all state returns to reset values in the same edge. A pending candidate is discarded; the first accept after reset is treated as UNLOCKED.
- digit_locked=1 iff state==LOCKED.

Decomposition:
- Package seg7_pkg holds:
  - Segment pattern constants SEG_DIGIT_0..SEG_DIGIT_9 (shared with the display encoder).
  - SEG_BLANK=7'h00.
  - Digit width 4 and DIGIT_MAX=9.
- One combinational sub-module, seg7_decode: pattern[6:0] -> digit[3:0] plus valid. It is the inverse of the encoder table, and both use the package constants.

Test Plan:
- Reset, then drive 3F held 10 cycles -> digit_strobe at edge 6, digit=0, digit_locked=1, period_valid=0, no flags.
- Drive 3F, 06, 5B, ..., 67, 3F, each held 100 cycles -> strobes every 100 cycles, period=100 with period_valid from the second strobe onward, 9->0 wrap, seq_error=0.
- Held 06, then a 3-cycle glitch to 7F, then back to 06 -> no strobe, digit stays 1. Same glitch held 4 cycles -> digit=8, seq_error=1.
- Drive 00 stable while locked -> bad_pattern=1, digit_locked=0, digit unchanged. Then 5B -> strobe, digit=2, no period_valid, seq_error unchanged.
- Set seq_error, then pulse clear_flags alone -> flag 0. Pulse clear_flags in the same cycle as a new sequence violation -> seq_error stays 1.
- With PERIOD_W=4, digits spaced 40 cycles -> period=15 (saturated). Assert reset mid-filter -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the reader.
// Segment bit i drives segment i+1: bit0 is the top bar, bit6 the middle bar.
package seg7_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    localparam logic [6:0] SEG_BLANK   = 7'h00;
    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7C;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h67;

    function automatic logic [DIGIT_W-1:0] next_digit(
        input logic [DIGIT_W-1:0] d
    );
        return (d >= DIGIT_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Inverse of the seven-segment encoder table; anything else,
// blank included, decodes as invalid.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0]         i_pattern,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_valid
);

    always_comb begin
        o_digit = '0;
        o_valid = 1'b1;
        unique case (i_pattern)
            SEG_DIGIT_0: o_digit = 4'd0;
            SEG_DIGIT_1: o_digit = 4'd1;
            SEG_DIGIT_2: o_digit = 4'd2;
            SEG_DIGIT_3: o_digit = 4'd3;
            SEG_DIGIT_4: o_digit = 4'd4;
            SEG_DIGIT_5: o_digit = 4'd5;
            SEG_DIGIT_6: o_digit = 4'd6;
            SEG_DIGIT_7: o_digit = 4'd7;
            SEG_DIGIT_8: o_digit = 4'd8;
            SEG_DIGIT_9: o_digit = 4'd9;
            default:     o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers the digit shown on an external seven-segment bus, checks the
// +1 mod 10 sequence and measures the clk period between digit changes.
module seven_segment_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    input  logic                clear_flags,
    output logic [6:0]          io_oeb,
    output logic [DIGIT_W-1:0]  digit,
    output logic                digit_strobe,
    output logic                digit_locked,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                bad_pattern,
    output logic                seq_error
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] PCNT_ONE = PERIOD_W'(1);

    logic [6:0]          r_sync1;
    logic [6:0]          r_sync2;
    logic [6:0]          r_cand;
    logic [6:0]          r_acc;
    logic [7:0]          r_cnt;
    logic                r_fresh;
    logic [0:0]          r_state;
    logic [PERIOD_W-1:0] r_pcnt;
    logic [PERIOD_W-1:0] r_period;
    logic [DIGIT_W-1:0]  r_digit;
    logic                r_strobe;
    logic                r_pvalid;
    logic                r_bad;
    logic                r_seq;

    logic [DIGIT_W-1:0]  w_dec_digit;
    logic                w_dec_valid;
    logic                w_accept;
    logic                w_set_bad;
    logic                w_set_seq;

    seg7_decode u_decode (
        .i_pattern (r_cand),
        .o_digit   (w_dec_digit),
        .o_valid   (w_dec_valid)
    );

    // r_fresh forces one accept of whatever settles first after reset,
    // even if it equals the reset value of the accepted pattern.
    assign w_accept  = (r_cnt == CNT_MAX) &&
                       ((r_cand != r_acc) || r_fresh);
    assign w_set_bad = w_accept && !w_dec_valid;
    assign w_set_seq = w_accept && w_dec_valid &&
                       (r_state == LOCKED) &&
                       (w_dec_digit != next_digit(r_digit));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_fresh <= 1'b1;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_accept) begin
                r_acc   <= r_cand;
                r_fresh <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= UNLOCKED;
            r_pcnt   <= '0;
            r_period <= '0;
            r_digit  <= '0;
            r_strobe <= 1'b0;
            r_pvalid <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_pvalid <= 1'b0;
            if (r_pcnt != PCNT_MAX) begin
                r_pcnt <= r_pcnt + PCNT_ONE;
            end
            if (w_accept && w_dec_valid) begin
                r_digit  <= w_dec_digit;
                r_strobe <= 1'b1;
                r_pcnt   <= PCNT_ONE;
                r_state  <= LOCKED;
                if (r_state == LOCKED) begin
                    r_period <= r_pcnt;
                    r_pvalid <= 1'b1;
                end
            end else if (w_accept) begin
                r_state <= UNLOCKED;
            end
        end
    end

    // A set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bad <= 1'b0;
            r_seq <= 1'b0;
        end else begin
            r_bad <= w_set_bad | (r_bad & ~clear_flags);
            r_seq <= w_set_seq | (r_seq & ~clear_flags);
        end
    end

    assign io_oeb       = 7'h7F;
    assign digit        = r_digit;
    assign digit_strobe = r_strobe;
    assign digit_locked = (r_state == LOCKED);
    assign period       = r_period;
    assign period_valid = r_pvalid;
    assign bad_pattern  = r_bad;
    assign seq_error    = r_seq;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: a table of held patterns plus
// hand-written glitch, flag and reset sequences, checked via a scoreboard.
module tb_seven_segment_reader;

    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       clear_flags;

    logic [6:0]  io_oeb;
    logic [3:0]  digit;
    logic        digit_strobe;
    logic        digit_locked;
    logic [23:0] period;
    logic        period_valid;
    logic        bad_pattern;
    logic        seq_error;

    logic [6:0] io_oeb2;
    logic [3:0] digit2;
    logic       strobe2;
    logic       locked2;
    logic [3:0] period2;
    logic       pvalid2;
    logic       bad2;
    logic       seq2;

    seven_segment_reader #(.STABLE_CYCLES(4), .PERIOD_W(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .clear_flags  (clear_flags),
        .io_oeb       (io_oeb),
        .digit        (digit),
        .digit_strobe (digit_strobe),
        .digit_locked (digit_locked),
        .period       (period),
        .period_valid (period_valid),
        .bad_pattern  (bad_pattern),
        .seq_error    (seq_error)
    );

    seven_segment_reader #(.STABLE_CYCLES(4), .PERIOD_W(4)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .clear_flags  (clear_flags),
        .io_oeb       (io_oeb2),
        .digit        (digit2),
        .digit_strobe (strobe2),
        .digit_locked (locked2),
        .period       (period2),
        .period_valid (pvalid2),
        .bad_pattern  (bad2),
        .seq_error    (seq2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] pat;
        int         hold;
        bit         strb;
        logic [3:0] dig;
        bit         pv;
        int         per;
        bit         seq;
        bit         bad;
        bit         lck;
    } row_t;

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        bit         pv;
        int         per;
        bit         seq;
    } exp_t;

    row_t rows [18];
    exp_t sb [$];
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   last_drive;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        int   p2;
        @(posedge clk);
        #1;
        cyc++;
        if (digit_strobe) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_strobe: digit %0d at cyc %0d",
                         digit, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_cyc", cyc, e.cyc);
                check("strobe_digit", digit, e.dig);
                check("strobe_pvalid", period_valid, e.pv);
                check("strobe_seq", seq_error, e.seq);
                check("strobe2", strobe2, 1);
                check("pvalid2", pvalid2, e.pv);
                if (e.pv) begin
                    p2 = (e.per > 15) ? 15 : e.per;
                    check("period", period, e.per);
                    check("period_sat", period2, p2);
                end
            end
        end else if (period_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL pvalid_alone: got 1, expected 0 (cyc %0d)",
                     cyc);
        end
    endtask

    task automatic drive(input logic [6:0] pat, input bit strb,
                         input logic [3:0] dig, input bit pv,
                         input int per, input bit seq);
        exp_t e;
        seg_in = pat;
        if (strb) begin
            e.cyc = cyc + LAT;
            e.dig = dig;
            e.pv  = pv;
            e.per = per;
            e.seq = seq;
            sb.push_back(e);
        end
        last_drive = cyc;
    endtask

    initial begin
        int p;
        rows[0]  = '{7'h3F, 10,  1, 4'd0, 0, 0,   0, 0, 1};
        rows[1]  = '{7'h06, 100, 1, 4'd1, 1, 10,  0, 0, 1};
        rows[2]  = '{7'h5B, 100, 1, 4'd2, 1, 100, 0, 0, 1};
        rows[3]  = '{7'h4F, 100, 1, 4'd3, 1, 100, 0, 0, 1};
        rows[4]  = '{7'h66, 100, 1, 4'd4, 1, 100, 0, 0, 1};
        rows[5]  = '{7'h6D, 100, 1, 4'd5, 1, 100, 0, 0, 1};
        rows[6]  = '{7'h7C, 100, 1, 4'd6, 1, 100, 0, 0, 1};
        rows[7]  = '{7'h07, 100, 1, 4'd7, 1, 100, 0, 0, 1};
        rows[8]  = '{7'h7F, 100, 1, 4'd8, 1, 100, 0, 0, 1};
        rows[9]  = '{7'h67, 100, 1, 4'd9, 1, 100, 0, 0, 1};
        rows[10] = '{7'h3F, 100, 1, 4'd0, 1, 100, 0, 0, 1};
        rows[11] = '{7'h06, 50,  1, 4'd1, 1, 100, 0, 0, 1};
        rows[12] = '{7'h7F, 3,   0, 4'd1, 0, 0,   0, 0, 1};
        rows[13] = '{7'h06, 30,  0, 4'd1, 0, 0,   0, 0, 1};
        rows[14] = '{7'h7F, 4,   1, 4'd8, 1, 83,  1, 0, 1};
        rows[15] = '{7'h06, 20,  1, 4'd1, 1, 4,   1, 0, 1};
        rows[16] = '{7'h00, 20,  0, 4'd1, 0, 0,   1, 1, 0};
        rows[17] = '{7'h5B, 20,  1, 4'd2, 0, 0,   1, 1, 1};

        cyc         = 0;
        n_tests     = 0;
        n_fail      = 0;
        last_drive  = 0;
        reset       = 1'b1;
        seg_in      = 7'h00;
        clear_flags = 1'b0;
        repeat (3) tick();

        check("rst_io_oeb", io_oeb, 7'h7F);
        check("rst_digit", digit, 0);
        check("rst_strobe", digit_strobe, 0);
        check("rst_locked", digit_locked, 0);
        check("rst_period", period, 0);
        check("rst_pvalid", period_valid, 0);
        check("rst_bad", bad_pattern, 0);
        check("rst_seq", seq_error, 0);

        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(rows[i].pat, rows[i].strb, rows[i].dig,
                  rows[i].pv, rows[i].per, rows[i].seq);
            repeat (rows[i].hold) tick();
            if (rows[i].hold > LAT) begin
                check("row_digit", digit, rows[i].dig);
                check("row_seq", seq_error, rows[i].seq);
                check("row_bad", bad_pattern, rows[i].bad);
                check("row_locked", digit_locked, rows[i].lck);
            end
        end

        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clr_seq", seq_error, 0);
        check("clr_bad", bad_pattern, 0);

        // New violation (2 -> 8) landing on the same edge as clear_flags.
        p = cyc - last_drive;
        drive(7'h7F, 1, 4'd8, 1, p, 1);
        repeat (LAT - 1) tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("set_wins_seq", seq_error, 1);
        check("set_wins_bad", bad_pattern, 0);
        repeat (10) tick();

        p = cyc - last_drive;
        drive(7'h67, 1, 4'd9, 1, p, 1);
        repeat (40) tick();
        drive(7'h3F, 1, 4'd0, 1, 40, 1);
        repeat (40) tick();
        check("per40", period, 40);
        check("per40_sat", period2, 15);

        // Reset while 06 is still inside the stability filter.
        drive(7'h06, 0, 4'd0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("mid_digit", digit, 0);
        check("mid_strobe", digit_strobe, 0);
        check("mid_locked", digit_locked, 0);
        check("mid_period", period, 0);
        check("mid_pvalid", period_valid, 0);
        check("mid_bad", bad_pattern, 0);
        check("mid_seq", seq_error, 0);
        check("mid_digit2", digit2, 0);
        check("mid_period2", period2, 0);
        reset = 1'b0;
        drive(7'h06, 1, 4'd1, 0, 0, 0);
        repeat (12) tick();
        check("post_locked", digit_locked, 1);
        check("post_digit", digit, 1);
        check("post_seq", seq_error, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
